stopwatch_display_mux: RTL and testbench
========================================

Name: stopwatch_display_mux

Overview:
- Downstream stage of the stopwatch counter.
- Consumes the six BCD digit outputs and the mode/display-enable line, and drives a time-multiplexed 6-digit active-low seven-segment display.
- Scans one digit per scan tick.
- Digits are snapshotted once per frame so a frame never tears.
- Applies leading-zero blanking and decimal points (M.SS.hh style).

Parameters:
- SCAN_DIV, 1: clock cycles per digit slot; legal range 1..65535.
- LZ_BLANK, 1: 1 enables leading-zero blanking on digit positions 5, 4 and 3.

Ports:
- clk  input  1  system clock; same clock as the stopwatch counter.
- reset  input  1  synchronous, active-high reset.
- display_en  input  1  stopwatch mode line; 0 turns all anodes off while scanning continues.
- timer10ms  input  4  BCD digit, position 0 (rightmost).
- timer100ms  input  4  BCD digit, position 1.
- timer1sec  input  4  BCD digit, position 2.
- timer10sec  input  4  BCD digit, position 3.
- timer1min  input  4  BCD digit, position 4.
- timer10min  input  4  BCD digit, position 5 (leftmost).
- an  output  6  digit anodes, active-low; an[i] selects position i.
- seg  output  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  output  1  decimal point, active-low.

Behaviour:
- State: prescaler pre (0..SCAN_DIV-1), digit index idx (0..5), 24-bit snapshot snap.
- Reset, sampled on the clock edge, gives next cycle:
  - an=6'b111111, seg=7'b1111111, dp=1.
  - pre=0, idx=0.
  - snap loads the live inputs on every reset cycle.
- Tick: tick = (pre==SCAN_DIV-1). Each non-reset edge:
  - pre <= tick ? 0 : pre+1.
  - On tick, idx <= (idx==5) ? 0 : idx+1.
  - With SCAN_DIV=1, idx advances every cycle.
- Snapshot: loads all six live digits on the edge where tick && idx==5, i.e. the same edge idx wraps to 0. snap is otherwise held; live input changes mid-frame are invisible until the next frame.
- Output stage: an/seg/dp are registered. Outputs in cycle n+1 are a function of idx, snap and display_en in cycle n (latency 1).
- Anode: an[idx]=0 and all other anodes 1. If display_en=0, an=6'b111111; seg/dp are still computed.
- Decode (active-high gfedcba shown; seg is its inverse):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any value 10..15 = 40 (dash).
- Leading-zero blanking (LZ_BLANK=1), evaluated on snap:
  - pos5 blank if d5==0.
  - pos4 blank if d5==0 && d4==0.
  - pos3 blank if d5==0 && d4==0 && d3==0.
  - Positions 2..0 are never blanked.
  - A blanked position keeps its anode active but drives seg=7'b1111111 and dp=1.
  - A dash digit (value >9) is non-zero for blanking purposes.
- Decimal point: dp=0 at position 2 (1sec) and position 4 (1min), unless that position is blanked. dp=1 elsewhere.
- Wrap: idx 5 -> 0 is seamless; no dead cycle.
- Reset mid-frame: outputs go inactive on the next edge. The scan restarts at idx 0 with a snapshot of the inputs present during the last reset cycle.
- Simultaneous events: a display_en change and a tick on the same edge both take effect on that edge.

Test Plan:
1. reset=1 for 2 cycles, then 0, with all inputs 0 -> during reset an=3F, seg=7F, dp=1. In the first post-reset cycles, an steps 111110, 111101, 111011 … with SCAN_DIV=1. Positions 5..3 show seg=7F, an active. Positions 2..0 show seg=~3F=7'b1000000. dp=0 only when an=111011.
2. Inputs 10min=0, 1min=1, 10sec=2, 1sec=3, 100ms=4, 10ms=5 loaded via reset -> over one frame:
   - pos0 seg=~6D, pos1 ~66, pos2 ~4F with dp=0, pos3 ~5B, pos4 ~06 with dp=0.
   - pos5 blanked (seg=7F, dp=1).
3. Change 10ms from 5 to 6 while idx=2 -> pos0 still shows ~6D for the rest of the frame; ~7D appears only after idx wraps to 0.
4. display_en=0 for 12 cycles -> an=111111 from the next cycle. idx keeps advancing: after re-enable, the lit position equals (elapsed cycles mod 6), not a restart.
5. timer1sec=4'hA -> pos2 seg=~40=7'b0111111, dp=0. With 10sec=0, 1min=0, 10min=0, pos3..5 are blanked.
6. SCAN_DIV=4 build -> each an value is held for exactly 4 cycles. A full frame is 24 cycles. The snapshot loads on cycle 24k-1 edges only.

Source files
------------

// File: rtl/stopwatch_display_mux.sv
// Six-digit multiplexed seven-segment driver for the stopwatch: per-frame digit snapshot,
// leading-zero blanking, M.SS.hh decimal points. Outputs registered, latency 1 cycle; no backpressure.
module stopwatch_display_mux #(
    parameter int unsigned SCAN_DIV = 1,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       display_en,
    input  logic [3:0] timer10ms,
    input  logic [3:0] timer100ms,
    input  logic [3:0] timer1sec,
    input  logic [3:0] timer10sec,
    input  logic [3:0] timer1min,
    input  logic [3:0] timer10min,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [15:0] PRE_MAX = 16'(SCAN_DIV - 1);

    logic [15:0] pre_q, pre_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] snap_q, snap_d;
    logic [5:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    logic [23:0] live;
    logic        tick;
    logic [3:0]  digit;
    logic        blank;

    // Active-high gfedcba; anything above 9 renders as a dash.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign live  = {timer10min, timer1min, timer10sec, timer1sec, timer100ms, timer10ms};
    assign tick  = (pre_q == PRE_MAX);
    assign digit = snap_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        blank = 1'b0;
        if (LZ_BLANK) begin
            case (idx_q)
                3'd5:    blank = (snap_q[23:20] == 4'd0);
                3'd4:    blank = (snap_q[23:16] == 8'd0);
                3'd3:    blank = (snap_q[23:12] == 12'd0);
                default: blank = 1'b0;
            endcase
        end
    end

    always_comb begin
        pre_d  = tick ? 16'd0 : pre_q + 16'd1;
        idx_d  = idx_q;
        if (tick) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        // Reload only at the frame boundary so a frame never mixes old and new digits.
        snap_d = (tick && idx_q == 3'd5) ? live : snap_q;
        an_d   = display_en ? ~(6'b000001 << idx_q) : 6'b111111;
        seg_d  = blank ? 7'b1111111 : ~decode(digit);
        dp_d   = ~(((idx_q == 3'd2) || (idx_q == 3'd4)) && !blank);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q  <= 16'd0;
            idx_q  <= 3'd0;
            snap_q <= live;
            an_q   <= 6'b111111;
            seg_q  <= 7'b1111111;
            dp_q   <= 1'b1;
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Directed bench for stopwatch_display_mux: one SCAN_DIV=1 instance and one SCAN_DIV=4 instance
// sharing stimulus; inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_stopwatch_display_mux;

    logic       clk;
    logic       reset;
    logic       display_en;
    logic [3:0] d0, d1, d2, d3, d4, d5;
    logic [5:0] an1, an4;
    logic [6:0] seg1, seg4;
    logic       dp1, dp4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    stopwatch_display_mux #(.SCAN_DIV(1), .LZ_BLANK(1'b1)) u_div1 (
        .clk(clk), .reset(reset), .display_en(display_en),
        .timer10ms(d0), .timer100ms(d1), .timer1sec(d2),
        .timer10sec(d3), .timer1min(d4), .timer10min(d5),
        .an(an1), .seg(seg1), .dp(dp1)
    );

    stopwatch_display_mux #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) u_div4 (
        .clk(clk), .reset(reset), .display_en(display_en),
        .timer10ms(d0), .timer100ms(d1), .timer1sec(d2),
        .timer10sec(d3), .timer1min(d4), .timer10min(d5),
        .an(an4), .seg(seg4), .dp(dp4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loads the given digits through a two-cycle reset; returns on the falling edge where reset drops.
    task automatic do_reset(input logic [3:0] v5, v4, v3, v2, v1, v0);
        @(negedge clk);
        {d5, d4, d3, d2, d1, d0} = {v5, v4, v3, v2, v1, v0};
        display_en = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [6:0] es [6];
        logic       ed [6];
        logic [5:0] ea;
        es = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
        ed = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        {d5, d4, d3, d2, d1, d0} = 24'h0;
        display_en = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({an1, seg1, dp1} !== {6'b111111, 7'b1111111, 1'b1})
            $display("FAIL reset_div1 got an=%b seg=%b dp=%b want an=111111 seg=1111111 dp=1", an1, seg1, dp1);
        else pass_cnt++;
        total_cnt++;
        if ({an4, seg4, dp4} !== {6'b111111, 7'b1111111, 1'b1})
            $display("FAIL reset_div4 got an=%b seg=%b dp=%b want an=111111 seg=1111111 dp=1", an4, seg4, dp4);
        else pass_cnt++;
        reset = 1'b0;
        for (int p = 0; p < 7; p++) begin
            @(negedge clk);
            ea = ~(6'b000001 << (p % 6));
            total_cnt++;
            if ({an1, seg1, dp1} !== {ea, es[p % 6], ed[p % 6]})
                $display("FAIL zeros_scan cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         p, an1, seg1, dp1, ea, es[p % 6], ed[p % 6]);
            else pass_cnt++;
        end
    endtask

    task automatic test_digit_patterns;
        logic [6:0] es [6];
        logic       ed [6];
        logic [5:0] ea;
        es = '{7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1111111};
        ed = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ea = ~(6'b000001 << k);
            total_cnt++;
            if ({an1, seg1, dp1} !== {ea, es[k], ed[k]})
                $display("FAIL digits pos=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         k, an1, seg1, dp1, ea, es[k], ed[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_snapshot;
        logic [6:0] es [12];
        logic       ed [12];
        logic [5:0] ea;
        es = '{7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1111111,
               7'b0000010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111000, 7'b1111111};
        ed = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        for (int p = 0; p < 12; p++) begin
            @(negedge clk);
            ea = ~(6'b000001 << (p % 6));
            total_cnt++;
            if ({an1, seg1, dp1} !== {ea, es[p], ed[p]})
                $display("FAIL snapshot cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         p, an1, seg1, dp1, ea, es[p], ed[p]);
            else pass_cnt++;
            if (p == 1) begin
                d0 = 4'd6;
                d4 = 4'd7;
            end
        end
    endtask

    task automatic test_display_en;
        logic [6:0] es [6];
        logic       ed [6];
        logic [5:0] ea;
        es = '{7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1111111};
        ed = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        for (int p = 1; p <= 15; p++) begin
            @(negedge clk);
            ea = (p >= 2 && p <= 13) ? 6'b111111 : ~(6'b000001 << ((p - 1) % 6));
            total_cnt++;
            if ({an1, seg1, dp1} !== {ea, es[(p - 1) % 6], ed[(p - 1) % 6]})
                $display("FAIL display_en cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         p, an1, seg1, dp1, ea, es[(p - 1) % 6], ed[(p - 1) % 6]);
            else pass_cnt++;
            if (p == 1)  display_en = 1'b0;
            if (p == 13) display_en = 1'b1;
        end
    endtask

    task automatic test_dash_blanking;
        logic [6:0] es [12];
        logic       ed [12];
        logic [5:0] ea;
        es = '{7'b1000000, 7'b1000000, 7'b0111111, 7'b1111111, 7'b1111111, 7'b1111111,
               7'b1000000, 7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000, 7'b0111111};
        ed = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int part = 0; part < 2; part++) begin
            if (part == 0) do_reset(4'd0, 4'd0, 4'd0, 4'hA, 4'd0, 4'd0);
            else           do_reset(4'hF, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0);
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                ea = ~(6'b000001 << k);
                total_cnt++;
                if ({an1, seg1, dp1} !== {ea, es[part * 6 + k], ed[part * 6 + k]})
                    $display("FAIL dash_blank part=%0d pos=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                             part, k, an1, seg1, dp1, ea, es[part * 6 + k], ed[part * 6 + k]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_scan_div4;
        logic [6:0] es [6];
        logic       ed [6];
        logic [5:0] ea;
        logic [6:0] sx;
        int         k;
        es = '{7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1111111};
        ed = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        for (int p = 1; p <= 28; p++) begin
            @(negedge clk);
            k  = ((p - 1) / 4) % 6;
            ea = ~(6'b000001 << k);
            // The 10ms digit is 9 only during the edge that closes the frame, so only that edge may capture it.
            sx = (p >= 25) ? 7'b0010000 : es[k];
            total_cnt++;
            if ({an4, seg4, dp4} !== {ea, sx, ed[k]})
                $display("FAIL div4_scan cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         p, an4, seg4, dp4, ea, sx, ed[k]);
            else pass_cnt++;
            if (p == 23) d0 = 4'd9;
            if (p == 24) d0 = 4'd7;
        end
    endtask

    initial begin
        reset = 1'b1;
        display_en = 1'b1;
        {d5, d4, d3, d2, d1, d0} = 24'h0;
        test_reset;
        test_digit_patterns;
        test_snapshot;
        test_display_en;
        test_dash_blanking;
        test_scan_div4;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
